// File: rtl/artec_dma_burst_sched_if.sv
// Handshake and bus bundle of the DMA burst scheduler.
// master = scheduler side, slave = FIFOs / arbiter / AXI AW side.
interface artec_dma_burst_sched_if #(
    parameter int NUM_CH     = 4,
    parameter int REQ_WIDTH  = 9,
    parameter int ADDR_WIDTH = 32
);
    localparam int CHW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]                 ch_en_i;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_base_i;
    logic [NUM_CH-1:0][REQ_WIDTH-1:0]  ch_level_i;
    logic                              drain_valid_i;
    logic [CHW-1:0]                    drain_ch_i;
    logic [NUM_CH-1:0][REQ_WIDTH-1:0]  arb_req_o;
    logic [CHW-1:0]                    grant_i;
    logic                              grant_valid_i;
    logic                              cmd_valid_o;
    logic                              cmd_ready_i;
    logic [CHW-1:0]                    cmd_ch_o;
    logic [ADDR_WIDTH-1:0]             cmd_addr_o;
    logic [7:0]                        cmd_len_o;
    logic                              bdone_valid_i;
    logic [CHW-1:0]                    bdone_ch_i;

    modport master (
        input  ch_en_i, ch_base_i, ch_level_i,
        input  drain_valid_i, drain_ch_i,
        input  grant_i, grant_valid_i,
        input  cmd_ready_i,
        input  bdone_valid_i, bdone_ch_i,
        output arb_req_o,
        output cmd_valid_o, cmd_ch_o, cmd_addr_o, cmd_len_o
    );

    modport slave (
        output ch_en_i, ch_base_i, ch_level_i,
        output drain_valid_i, drain_ch_i,
        output grant_i, grant_valid_i,
        output cmd_ready_i,
        output bdone_valid_i, bdone_ch_i,
        input  arb_req_o,
        input  cmd_valid_o, cmd_ch_o, cmd_addr_o, cmd_len_o
    );
endinterface

// File: rtl/artec_dma_burst_sched.sv
// DMA burst scheduler: turns arbiter grants into AXI AW burst commands
// bounded by data, max burst length and 4 KB pages of a per-channel ring.
module artec_dma_burst_sched #(
    parameter int NUM_CH     = 4,
    parameter int REQ_WIDTH  = 9,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BURST  = 16,
    parameter int MAX_OUTST  = 4,
    parameter int BUF_BYTES  = 16384
) (
    input logic clk,
    input logic rstn,
    input logic clear,
    artec_dma_burst_sched_if.master bus
);
    localparam int CHW  = $clog2(NUM_CH);
    localparam int OFFW = $clog2(BUF_BYTES);
    localparam int OSW  = $clog2(MAX_OUTST + 1);
    localparam int DSH  = $clog2(DATA_BYTES);
    localparam int BTW  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        CMD      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [OFFW-1:0]       off_q   [NUM_CH];
    logic [OFFW-1:0]       off_d   [NUM_CH];
    logic [REQ_WIDTH-1:0]  resv_q  [NUM_CH];
    logic [REQ_WIDTH-1:0]  resv_d  [NUM_CH];
    logic [OSW-1:0]        outst_q [NUM_CH];
    logic [OSW-1:0]        outst_d [NUM_CH];
    logic [REQ_WIDTH-1:0]  avail   [NUM_CH];
    logic [NUM_CH-1:0]     elig;

    logic [CHW-1:0]        g;
    logic                  grant_ok;
    logic                  hs;
    logic [12:0]           rem_bytes;
    logic [12:0]           bnd_beats;
    logic [BTW-1:0]        beats_d;

    logic [CHW-1:0]        ch_q;
    logic [BTW-1:0]        beats_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;

    logic                  inc;
    logic                  dr;
    logic                  bd;

    // Unreserved data per channel; level may lag a drain, so saturate.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            avail[i] = (bus.ch_level_i[i] > resv_q[i])
                     ? bus.ch_level_i[i] - resv_q[i]
                     : '0;
            elig[i]  = bus.ch_en_i[i]
                     && (avail[i] != '0)
                     && (outst_q[i] < OSW'(MAX_OUTST));
            bus.arb_req_o[i] = (state_q == IDLE && elig[i])
                             ? avail[i]
                             : '0;
        end
    end

    assign g        = bus.grant_i;
    assign grant_ok = bus.grant_valid_i && elig[g];
    assign hs       = (state_q == CMD) && bus.cmd_ready_i;

    // Burst size: min of available words, MAX_BURST and words left in the page.
    always_comb begin
        rem_bytes = 13'd4096 - {1'b0, off_q[g][11:0]};
        bnd_beats = rem_bytes >> DSH;
        beats_d   = BTW'(MAX_BURST);
        if (int'(avail[g]) < MAX_BURST)
            beats_d = BTW'(avail[g]);
        if (int'(bnd_beats) < int'(beats_d))
            beats_d = BTW'(bnd_beats);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else if (clear)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|elig)
                    state_d = WAIT_GNT;
            end
            WAIT_GNT: begin
                if (bus.grant_valid_i)
                    state_d = grant_ok ? CMD : IDLE;
            end
            CMD: begin
                if (bus.cmd_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_valid_o = (state_q == CMD);
        bus.cmd_ch_o    = ch_q;
        bus.cmd_addr_o  = addr_q;
        bus.cmd_len_o   = len_q;
    end

    // Command fields are captured at grant so they hold through CMD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_q    <= '0;
            beats_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else if (clear) begin
            ch_q    <= '0;
            beats_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else if (state_q == WAIT_GNT && grant_ok) begin
            ch_q    <= g;
            beats_q <= beats_d;
            addr_q  <= bus.ch_base_i[g] | ADDR_WIDTH'(off_q[g]);
            len_q   <= 8'(beats_d - BTW'(1));
        end
    end

    // A decrement on a zero counter is a protocol error and is ignored;
    // an increment in the same cycle keeps the sum nonzero.
    always_comb begin
        inc = 1'b0;
        dr  = 1'b0;
        bd  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            inc = hs && (ch_q == CHW'(i));
            dr  = bus.drain_valid_i && (bus.drain_ch_i == CHW'(i));
            bd  = bus.bdone_valid_i && (bus.bdone_ch_i == CHW'(i));

            resv_d[i] = resv_q[i]
                      + (inc ? REQ_WIDTH'(beats_q) : '0)
                      - ((dr && (inc || resv_q[i] != '0))
                         ? REQ_WIDTH'(1) : '0);

            outst_d[i] = outst_q[i]
                       + (inc ? OSW'(1) : '0)
                       - ((bd && (inc || outst_q[i] != '0))
                          ? OSW'(1) : '0);

            if (!bus.ch_en_i[i])
                off_d[i] = '0;
            else if (inc)
                off_d[i] = off_q[i] + OFFW'(32'(beats_q) << DSH);
            else
                off_d[i] = off_q[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                off_q[i]   <= '0;
                resv_q[i]  <= '0;
                outst_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                off_q[i]   <= '0;
                resv_q[i]  <= '0;
                outst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                off_q[i]   <= off_d[i];
                resv_q[i]  <= resv_d[i];
                outst_q[i] <= outst_d[i];
            end
        end
    end
endmodule

// File: tb/tb_artec_dma_burst_sched.sv
// Bench for artec_dma_burst_sched: bench-side arbiter and FIFO model,
// expected AW commands queued at grant and compared at handshake.
module tb_artec_dma_burst_sched;
    localparam int BUF = 16384;

    logic clk = 1'b0;
    logic rstn;
    logic clear;

    always #5 clk = ~clk;

    artec_dma_burst_sched_if bus ();

    artec_dma_burst_sched dut (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [7:0]  len;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          off_m  [4];
    int          resv_m [4];
    int          outst_m[4];
    int          lvl    [4];
    logic [31:0] base   [4];

    always @(negedge clk) begin
        if (rstn && bus.cmd_valid_o && bus.cmd_ready_i) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL cmd_unexpected got ch=%0d addr=%h len=%0d",
                         bus.cmd_ch_o, bus.cmd_addr_o, bus.cmd_len_o);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.cmd_ch_o !== mon_e.ch || bus.cmd_addr_o !== mon_e.addr
                    || bus.cmd_len_o !== mon_e.len) begin
                    failures++;
                    $display("FAIL cmd_fields got ch=%0d addr=%h len=%0d exp ch=%0d addr=%h len=%0d",
                             bus.cmd_ch_o, bus.cmd_addr_o, bus.cmd_len_o,
                             mon_e.ch, mon_e.addr, mon_e.len);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic set_lvl(input int ch, input int v);
        lvl[ch] = v;
        bus.ch_level_i[ch] = 9'(v);
    endtask

    task automatic clr_model();
        for (int i = 0; i < 4; i++) begin
            off_m[i]   = 0;
            resv_m[i]  = 0;
            outst_m[i] = 0;
        end
    endtask

    // Arbiter: grant one cycle after the request; simul adds drain+bdone at handshake.
    task automatic do_grant(input int ch, input bit simul,
                            output logic [31:0] oaddr, output logic [7:0] olen);
        int   n;
        int   av;
        int   bw;
        int   bt;
        exp_t e;
        n     = 0;
        oaddr = '0;
        olen  = '0;
        #1;
        while (bus.arb_req_o[ch] == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL req_timeout ch=%0d got=0 exp=nonzero", ch);
            return;
        end
        av = lvl[ch] - resv_m[ch];
        if (av < 0) av = 0;
        bw = (4096 - (off_m[ch] % 4096)) / 8;
        bt = av;
        if (bt > 16) bt = 16;
        if (bw < bt) bt = bw;
        e.ch   = 2'(ch);
        e.addr = base[ch] | 32'(off_m[ch]);
        e.len  = 8'(bt - 1);
        sbq.push_back(e);
        off_m[ch]   = (off_m[ch] + bt * 8) % BUF;
        resv_m[ch]  = resv_m[ch] + bt - (simul ? 1 : 0);
        outst_m[ch] = outst_m[ch] + 1 - (simul ? 1 : 0);
        @(posedge clk);
        #1;
        bus.grant_i       = 2'(ch);
        bus.grant_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.grant_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL cmd_latency got=%b exp=1", bus.cmd_valid_o);
        end
        oaddr = bus.cmd_addr_o;
        olen  = bus.cmd_len_o;
        if (simul) begin
            bus.drain_ch_i    = 2'(ch);
            bus.drain_valid_i = 1'b1;
            bus.bdone_ch_i    = 2'(ch);
            bus.bdone_valid_i = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.drain_valid_i = 1'b0;
        bus.bdone_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain_all(input int ch);
        if (resv_m[ch] > 0) begin
            bus.drain_ch_i    = 2'(ch);
            bus.drain_valid_i = 1'b1;
            repeat (resv_m[ch]) @(posedge clk);
            #1;
            bus.drain_valid_i = 1'b0;
        end
        if (outst_m[ch] > 0) begin
            bus.bdone_ch_i    = 2'(ch);
            bus.bdone_valid_i = 1'b1;
            repeat (outst_m[ch]) @(posedge clk);
            #1;
            bus.bdone_valid_i = 1'b0;
        end
        resv_m[ch]  = 0;
        outst_m[ch] = 0;
        @(negedge clk);
    endtask

    task automatic advance(input int ch, input int words);
        logic [31:0] a;
        logic [7:0]  l;
        set_lvl(ch, words);
        do_grant(ch, 1'b0, a, l);
        set_lvl(ch, 0);
        drain_all(ch);
    endtask

    task automatic test_reset();
        rstn              = 1'b0;
        clear             = 1'b0;
        bus.ch_en_i       = '0;
        bus.ch_base_i     = '0;
        bus.ch_level_i    = '0;
        bus.drain_valid_i = 1'b0;
        bus.drain_ch_i    = '0;
        bus.grant_i       = '0;
        bus.grant_valid_i = 1'b0;
        bus.cmd_ready_i   = 1'b1;
        bus.bdone_valid_i = 1'b0;
        bus.bdone_ch_i    = '0;
        for (int i = 0; i < 4; i++) begin
            lvl[i]  = 0;
            base[i] = '0;
        end
        clr_model();
        #1;
        checks++;
        if (bus.cmd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", bus.cmd_valid_o);
        end
        checks++;
        if (bus.cmd_ch_o !== 2'd0) begin
            failures++;
            $display("FAIL rst_ch got=%0d exp=0", bus.cmd_ch_o);
        end
        checks++;
        if (bus.cmd_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_addr got=%h exp=0", bus.cmd_addr_o);
        end
        checks++;
        if (bus.cmd_len_o !== 8'h0) begin
            failures++;
            $display("FAIL rst_len got=%0d exp=0", bus.cmd_len_o);
        end
        checks++;
        if (bus.arb_req_o !== '0) begin
            failures++;
            $display("FAIL rst_req got=%h exp=0", bus.arb_req_o);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] a;
        logic [7:0]  l;
        base[0]          = 32'h1000_0000;
        bus.ch_base_i[0] = base[0];
        bus.ch_en_i[0]   = 1'b1;
        set_lvl(0, 40);
        do_grant(0, 1'b0, a, l);
        checks++;
        if (a !== 32'h1000_0000 || l !== 8'd15) begin
            failures++;
            $display("FAIL basic_b0 got addr=%h len=%0d exp addr=10000000 len=15", a, l);
        end
        do_grant(0, 1'b0, a, l);
        checks++;
        if (a !== 32'h1000_0080 || l !== 8'd15) begin
            failures++;
            $display("FAIL basic_b1 got addr=%h len=%0d exp addr=10000080 len=15", a, l);
        end
        do_grant(0, 1'b0, a, l);
        checks++;
        if (a !== 32'h1000_0100 || l !== 8'd7) begin
            failures++;
            $display("FAIL basic_b2 got addr=%h len=%0d exp addr=10000100 len=7", a, l);
        end
        checks++;
        if (bus.arb_req_o[0] !== 9'd0) begin
            failures++;
            $display("FAIL basic_resv_full got=%0d exp=0", bus.arb_req_o[0]);
        end
        set_lvl(0, 41);
        #1;
        checks++;
        if (bus.arb_req_o[0] !== 9'd1) begin
            failures++;
            $display("FAIL basic_resv40 got=%0d exp=1", bus.arb_req_o[0]);
        end
        set_lvl(0, 0);
        @(negedge clk);
        drain_all(0);
        bus.ch_en_i[0] = 1'b0;
        off_m[0] = 0;
        @(negedge clk);
    endtask

    task automatic test_4k_boundary();
        logic [31:0] a;
        logic [7:0]  l;
        base[1]          = 32'h2000_0000;
        bus.ch_base_i[1] = base[1];
        bus.ch_en_i[1]   = 1'b1;
        for (int k = 0; k < 31; k++) advance(1, 16);
        advance(1, 12);
        set_lvl(1, 16);
        do_grant(1, 1'b0, a, l);
        checks++;
        if (a !== 32'h2000_0FE0 || l !== 8'd3) begin
            failures++;
            $display("FAIL page_tail got addr=%h len=%0d exp addr=20000fe0 len=3", a, l);
        end
        do_grant(1, 1'b0, a, l);
        checks++;
        if (a !== 32'h2000_1000 || l !== 8'd11) begin
            failures++;
            $display("FAIL page_next got addr=%h len=%0d exp addr=20001000 len=11", a, l);
        end
        set_lvl(1, 0);
        drain_all(1);
        bus.ch_en_i[1] = 1'b0;
        off_m[1] = 0;
        @(negedge clk);
    endtask

    task automatic test_ring_wrap();
        logic [31:0] a;
        logic [7:0]  l;
        base[2]          = 32'h3000_0000;
        bus.ch_base_i[2] = base[2];
        bus.ch_en_i[2]   = 1'b1;
        for (int k = 0; k < 127; k++) advance(2, 16);
        set_lvl(2, 32);
        do_grant(2, 1'b0, a, l);
        checks++;
        if (a !== 32'h3000_3F80 || l !== 8'd15) begin
            failures++;
            $display("FAIL wrap_last got addr=%h len=%0d exp addr=30003f80 len=15", a, l);
        end
        do_grant(2, 1'b0, a, l);
        checks++;
        if (a !== 32'h3000_0000 || l !== 8'd15) begin
            failures++;
            $display("FAIL wrap_first got addr=%h len=%0d exp addr=30000000 len=15", a, l);
        end
        set_lvl(2, 0);
        drain_all(2);
        bus.ch_en_i[2] = 1'b0;
        off_m[2] = 0;
        @(negedge clk);
    endtask

    task automatic test_outst_limit();
        logic [31:0] a;
        logic [7:0]  l;
        base[3]          = 32'h4000_0000;
        bus.ch_base_i[3] = base[3];
        bus.ch_en_i[3]   = 1'b1;
        set_lvl(3, 100);
        for (int k = 0; k < 4; k++) do_grant(3, 1'b0, a, l);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.arb_req_o[3] !== 9'd0) begin
                failures++;
                $display("FAIL outst_block got=%0d exp=0", bus.arb_req_o[3]);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.bdone_ch_i    = 2'd3;
        bus.bdone_valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.arb_req_o[3] !== 9'd0) begin
            failures++;
            $display("FAIL outst_same_cycle got=%0d exp=0", bus.arb_req_o[3]);
        end
        @(posedge clk);
        #1;
        bus.bdone_valid_i = 1'b0;
        outst_m[3]--;
        @(negedge clk);
        checks++;
        if (bus.arb_req_o[3] !== 9'd36) begin
            failures++;
            $display("FAIL outst_release got=%0d exp=36", bus.arb_req_o[3]);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] a;
        logic [7:0]  l;
        do_grant(3, 1'b1, a, l);
        checks++;
        if (a !== 32'h4000_0200 || l !== 8'd15) begin
            failures++;
            $display("FAIL simul_cmd got addr=%h len=%0d exp addr=40000200 len=15", a, l);
        end
        checks++;
        if (bus.arb_req_o[3] !== 9'd21) begin
            failures++;
            $display("FAIL simul_resv got=%0d exp=21", bus.arb_req_o[3]);
        end
        do_grant(3, 1'b0, a, l);
        checks++;
        if (bus.arb_req_o[3] !== 9'd0) begin
            failures++;
            $display("FAIL simul_outst got=%0d exp=0", bus.arb_req_o[3]);
        end
    endtask

    task automatic test_clear_disable();
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        clr_model();
        @(negedge clk);
        checks++;
        if (bus.arb_req_o[3] !== 9'd100) begin
            failures++;
            $display("FAIL clear_req got=%0d exp=100", bus.arb_req_o[3]);
        end
        @(posedge clk);
        #1;
        bus.ch_en_i[3]    = 1'b0;
        set_lvl(3, 0);
        bus.grant_i       = 2'd3;
        bus.grant_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.grant_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cmd_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL disable_no_cmd got=%b exp=0", bus.cmd_valid_o);
            end
        end
        checks++;
        if (bus.arb_req_o !== '0) begin
            failures++;
            $display("FAIL disable_req got=%h exp=0", bus.arb_req_o);
        end
    endtask

    task automatic test_reset_in_cmd();
        int n;
        n                = 0;
        bus.cmd_ready_i  = 1'b0;
        bus.ch_en_i[1]   = 1'b1;
        set_lvl(1, 8);
        #1;
        while (bus.arb_req_o[1] == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL rcmd_req_timeout got=0 exp=8");
        end
        @(posedge clk);
        #1;
        bus.grant_i       = 2'd1;
        bus.grant_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.grant_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_valid_o !== 1'b1 || bus.cmd_len_o !== 8'd7
            || bus.cmd_addr_o !== 32'h2000_0000) begin
            failures++;
            $display("FAIL rcmd_hold got v=%b addr=%h len=%0d exp v=1 addr=20000000 len=7",
                     bus.cmd_valid_o, bus.cmd_addr_o, bus.cmd_len_o);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.cmd_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rcmd_drop got=%b exp=0", bus.cmd_valid_o);
        end
        @(negedge clk);
        rstn            = 1'b1;
        bus.cmd_ready_i = 1'b1;
        clr_model();
        #1;
        checks++;
        if (bus.arb_req_o[1] !== 9'd8) begin
            failures++;
            $display("FAIL rcmd_after got=%0d exp=8", bus.arb_req_o[1]);
        end
        set_lvl(1, 0);
        bus.ch_en_i[1] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k_boundary();
        test_ring_wrap();
        test_outst_limit();
        test_simultaneous();
        test_clear_disable();
        test_reset_in_cmd();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/artec_dma_burst_sched.md
# artec_dma_burst_sched

Burst scheduler between the per-channel write FIFOs and the AXI write-address channel of the DMA. Presents per-channel pending-word counts to the round-robin channel arbiter, takes its grant, and turns it into one AXI write burst command sized by data availability, a maximum burst length and 4 KB boundaries. Each channel's write pointer wraps inside a power-of-two ring buffer. The block tracks reserved words and outstanding bursts so that data is never double-issued and no channel overruns its response budget.

## Interface
- NUM_CH, 4, number of DMA channels; power of two, ≥ 2
- REQ_WIDTH, 9, width of the per-channel FIFO level and of the arbiter request field
- ADDR_WIDTH, 32, AXI address width
- DATA_BYTES, 8, bytes per beat; power of two
- MAX_BURST, 16, maximum beats per burst; ≤ 256
- MAX_OUTST, 4, maximum outstanding bursts per channel
- BUF_BYTES, 16384, ring buffer size per channel; power of two, multiple of 4096
---
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear; same effect as reset
- ch_en_i  in  NUM_CH  channel enable
- ch_base_i  in  NUM_CH×ADDR_WIDTH  ring base per channel; aligned to BUF_BYTES; sampled while the channel is disabled
- ch_level_i  in  NUM_CH×REQ_WIDTH  words present in each channel's write FIFO
- drain_valid_i  in  1  one beat left a channel FIFO toward W
- drain_ch_i  in  clog2(NUM_CH)  channel of the drained beat
- arb_req_o  out  NUM_CH×REQ_WIDTH  request to the arbiter
- grant_i  in  clog2(NUM_CH)  arbiter grant index
- grant_valid_i  in  1  grant strobe (one cycle)
- cmd_valid_o  out  1  burst command valid
- cmd_ready_i  in  1  command accepted
- cmd_ch_o  out  clog2(NUM_CH)  channel of the command
- cmd_addr_o  out  ADDR_WIDTH  burst start address
- cmd_len_o  out  8  AXI awlen (beats−1)
- bdone_valid_i  in  1  B response received
- bdone_ch_i  in  clog2(NUM_CH)  channel of the B response

## Operation
- Per-channel registers:
  - off[i]: byte offset, log2(BUF_BYTES) bits
  - resv[i]: words issued but not yet drained, REQ_WIDTH bits
  - outst[i]: clog2(MAX_OUTST+1) bits
- avail[i] = ch_level_i[i] − resv[i], saturating at 0.
- A channel is eligible when ch_en_i[i], avail[i] ≠ 0, and outst[i] < MAX_OUTST.
- arb_req_o[i] = avail[i] if eligible and state is IDLE, else 0.
- FSM states are IDLE, WAIT_GNT and CMD.
  - IDLE → WAIT_GNT when any arb_req_o is nonzero.
  - WAIT_GNT → CMD on grant_valid_i when the granted channel is still eligible. Latch ch=grant_i and beats=min(avail, MAX_BURST, (4096 − off[ch] mod 4096)/DATA_BYTES).
  - WAIT_GNT → IDLE on grant_valid_i when the granted channel is no longer eligible (for example, it was disabled). No command is issued.
  - CMD: cmd_valid_o=1. All command fields stay stable until the handshake. On cmd_valid_o & cmd_ready_i → IDLE.
- On command handshake:
  - off[ch] ← (off[ch] + beats·DATA_BYTES) mod BUF_BYTES. Wrap is natural because BUF_BYTES is a multiple of 4 KB and bursts never cross 4 KB.
  - resv[ch] += beats
  - outst[ch] += 1
- cmd_addr_o = ch_base_i[ch] | off[ch]; cmd_len_o = beats − 1.
- drain_valid_i decrements resv[drain_ch_i]; bdone_valid_i decrements outst[bdone_ch_i].
- Simultaneous events:
  - Increment and decrement of the same counter in one cycle: apply both. Net for outst is unchanged; net for resv is +beats−1.
  - Drain or B response for a channel with a zero counter is a protocol error. The counter holds at 0 and does not wrap.
- While ch_en_i[i]=0, off[i] is reset to 0. resv and outst keep counting down so in-flight traffic completes.
- Reset/clear mid-operation: all counters, offsets and the FSM return to reset values immediately, and any pending command is dropped.

## Timing
- Reset values:
  - state IDLE; cmd_valid_o=0; cmd_ch_o=0; cmd_addr_o=0; cmd_len_o=0
  - arb_req_o=0 (while all channels are disabled)
  - off, resv and outst all 0
- arb_req_o is combinational from registers and ch_level_i.
- The arbiter strobes grant_valid_i one cycle after it sees a nonzero request. IDLE→WAIT_GNT→CMD gives cmd_valid_o two cycles after the first request cycle.
- Command handshake at cycle N: counters update at N+1. The next arb_req_o is visible at N+1 (IDLE), so the best case is one command per 3 cycles.
- Drain and B-response decrements take effect in the cycle after the strobe.

## Test plan
- Single channel, base 0x1000_0000, level 40, cmd_ready_i=1 → commands at addresses 0x…000, 0x…080 and 0x…100 with awlen 15, 15 and 7. resv reaches 40.
- off=0xFE0 (4 words before the 4 KB boundary), level 16 → awlen 3; the next command is at off 0x1000 with awlen 11.
- Ring wrap with BUF_BYTES=4096: off=0xF80, 16 words → awlen 15 at 0xF80; the next command is at off 0 (base address).
- outst reaches 4 with no B responses → arb_req_o[ch]=0. One bdone for that channel → the request reappears the next cycle.
- Drain, bdone and a command handshake in the same cycle on the same channel → outst unchanged, resv=+beats−1.
- Channel disabled between request and grant → return to IDLE, cmd_valid_o stays 0. Reset asserted during CMD → cmd_valid_o=0 immediately.
